// File: rtl/instr_loader_pkg.sv
// ----------------------------------------------------------------------------
// instr_loader_pkg
// Shared definitions for the program loader and the CPU controller:
//   - state_t           : loader FSM state encoding
//   - OP_*              : opcode constants of the instruction set
//   - LEGAL_OPS         : packed list of every opcode the loader accepts
//   - NUM_LEGAL_OPS     : number of entries in LEGAL_OPS
// ----------------------------------------------------------------------------
package instr_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HEADER  = 3'd1,
      S_COLLECT = 3'd2,
      S_WRITE   = 3'd3,
      S_DONE    = 3'd4,
      S_ERR     = 3'd5
   } state_t;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_SLTI    = 6'b001010;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_LW      = 6'b100011;
   localparam logic [5:0] OP_SW      = 6'b101011;
   localparam logic [5:0] OP_ADDI    = 6'b001000;
   localparam logic [5:0] OP_CUSTOM  = 6'b110011;

   localparam int NUM_LEGAL_OPS = 8;

   // Entry gi lives at bits [gi*6 +: 6]; OP_SPECIAL is entry 0.
   localparam logic [NUM_LEGAL_OPS*6-1:0] LEGAL_OPS = {
      OP_CUSTOM, OP_ADDI, OP_SW, OP_LW, OP_JAL, OP_J, OP_SLTI, OP_SPECIAL
   };

endpackage

// File: rtl/instr_loader_opcode_check.sv
// ----------------------------------------------------------------------------
// opcode_check
// Combinational legality test of an instruction opcode.
//   opcode : input  6-bit opcode field (instruction bits [31:26])
//   legal  : output 1 when the opcode is in the supported instruction set
// ----------------------------------------------------------------------------
module opcode_check
   import instr_loader_pkg::*;
(
   input  logic [5:0] opcode,
   output logic       legal
);

   logic [NUM_LEGAL_OPS-1:0] hit;

   for (genvar gi = 0; gi < NUM_LEGAL_OPS; gi++) begin : g_match
      assign hit[gi] = (opcode == LEGAL_OPS[gi*6 +: 6]);
   end

   assign legal = |hit;

endmodule

// File: rtl/instr_loader.sv
// ----------------------------------------------------------------------------
// instr_loader
// Receives a program as a byte stream (count byte N, then N big-endian 32-bit
// words), checks each opcode and writes legal words into instruction memory
// while holding the CPU in reset. Releases the CPU once all N words are in.
//   clk, reset          : clock, synchronous active-low reset
//   start               : one-cycle pulse, begins a load (IDLE/DONE/ERR only)
//   rx_data/valid/ready : byte stream handshake, transfer on valid & ready
//   imem_we/addr/wdata  : instruction memory write port
//   cpu_hold            : 1 keeps CPU and controller in reset
//   done                : program loaded, CPU running
//   error, err_addr     : load aborted, word index responsible
// ----------------------------------------------------------------------------
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] err_addr
);

   state_t            state_reg;
   logic              rx_ready_reg;
   logic              imem_we_reg;
   logic [ADDR_W-1:0] imem_addr_reg;
   logic [31:0]       imem_wdata_reg;
   logic              cpu_hold_reg;
   logic              done_reg;
   logic              error_reg;
   logic [ADDR_W-1:0] err_addr_reg;

   logic [ADDR_W-1:0] addr_reg;
   logic [1:0]        byte_cnt_reg;
   logic [7:0]        n_reg;
   logic [31:0]       word_reg;

   logic [31:0]       word_next;
   logic              opcode_legal;
   logic              transfer;
   logic              header_bad;
   logic              last_word;

   // Bytes shift in from the bottom, so after four transfers the first byte
   // sits in [31:24]. The opcode is judged on the word as it will be written.
   assign word_next  = {word_reg[23:0], rx_data};
   assign transfer   = rx_valid && rx_ready_reg;
   assign header_bad = (rx_data == 8'd0) || (32'(rx_data) > 32'(DEPTH));
   assign last_word  = (32'(addr_reg) == (32'(n_reg) - 32'd1));

   opcode_check u_opcode_check (
      .opcode (word_next[31:26]),
      .legal  (opcode_legal)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg      <= S_IDLE;
         rx_ready_reg   <= 1'b0;
         imem_we_reg    <= 1'b0;
         imem_addr_reg  <= '0;
         imem_wdata_reg <= '0;
         cpu_hold_reg   <= 1'b1;
         done_reg       <= 1'b0;
         error_reg      <= 1'b0;
         err_addr_reg   <= '0;
         addr_reg       <= '0;
         byte_cnt_reg   <= '0;
         n_reg          <= '0;
         word_reg       <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  state_reg    <= S_HEADER;
                  rx_ready_reg <= 1'b1;
               end
            end

            S_HEADER: begin
               if (transfer) begin
                  if (header_bad) begin
                     state_reg    <= S_ERR;
                     rx_ready_reg <= 1'b0;
                     error_reg    <= 1'b1;
                     err_addr_reg <= '0;
                  end else begin
                     state_reg    <= S_COLLECT;
                     n_reg        <= rx_data;
                     addr_reg     <= '0;
                     byte_cnt_reg <= '0;
                     word_reg     <= '0;
                  end
               end
            end

            S_COLLECT: begin
               if (transfer) begin
                  word_reg     <= word_next;
                  byte_cnt_reg <= byte_cnt_reg + 2'd1;
                  if (byte_cnt_reg == 2'd3) begin
                     // The write strobe doubles as the legality flag that
                     // WRITE consults to choose between advancing and ERR.
                     state_reg      <= S_WRITE;
                     rx_ready_reg   <= 1'b0;
                     imem_we_reg    <= opcode_legal;
                     imem_addr_reg  <= addr_reg;
                     imem_wdata_reg <= word_next;
                  end
               end
            end

            S_WRITE: begin
               imem_we_reg <= 1'b0;
               if (imem_we_reg) begin
                  if (last_word) begin
                     state_reg    <= S_DONE;
                     cpu_hold_reg <= 1'b0;
                     done_reg     <= 1'b1;
                  end else begin
                     state_reg    <= S_COLLECT;
                     addr_reg     <= addr_reg + ADDR_W'(1);
                     rx_ready_reg <= 1'b1;
                  end
               end else begin
                  state_reg    <= S_ERR;
                  error_reg    <= 1'b1;
                  err_addr_reg <= addr_reg;
               end
            end

            S_DONE: begin
               if (start) begin
                  state_reg    <= S_HEADER;
                  cpu_hold_reg <= 1'b1;
                  done_reg     <= 1'b0;
                  rx_ready_reg <= 1'b1;
               end
            end

            S_ERR: begin
               if (start) begin
                  state_reg    <= S_HEADER;
                  error_reg    <= 1'b0;
                  rx_ready_reg <= 1'b1;
               end
            end

            default: begin
               state_reg    <= S_IDLE;
               rx_ready_reg <= 1'b0;
               imem_we_reg  <= 1'b0;
               cpu_hold_reg <= 1'b1;
               done_reg     <= 1'b0;
            end
         endcase
      end
   end

   assign rx_ready   = rx_ready_reg;
   assign imem_we    = imem_we_reg;
   assign imem_addr  = imem_addr_reg;
   assign imem_wdata = imem_wdata_reg;
   assign cpu_hold   = cpu_hold_reg;
   assign done       = done_reg;
   assign error      = error_reg;
   assign err_addr   = err_addr_reg;

endmodule

// File: tb/tb_instr_loader.sv
// ----------------------------------------------------------------------------
// tb_instr_loader
// Directed scenarios for instr_loader. Every legal word whose last byte is
// handed over is queued with its address and the cycle its write is due; a
// monitor on the falling edge pops and compares each imem_we pulse.
// ----------------------------------------------------------------------------
module tb_instr_loader;

   localparam int DEPTH  = 64;
   localparam int ADDR_W = 6;

   logic              clk;
   logic              reset;
   logic              start;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_hold;
   logic              done;
   logic              error;
   logic [ADDR_W-1:0] err_addr;

   instr_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error),
      .err_addr   (err_addr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
      int                due;
   } exp_t;

   exp_t sb[$];
   int   checks  = 0;
   int   errors  = 0;
   int   neg_cnt = 0;

   // Write monitor: every imem_we pulse must match the oldest queued word,
   // including the falling edge on which it is due.
   always @(negedge clk) begin
      exp_t e;
      neg_cnt++;
      if (imem_we === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", imem_addr, imem_wdata);
         end else begin
            e = sb.pop_front();
            if (imem_addr !== e.addr || imem_wdata !== e.data || neg_cnt != e.due) begin
               errors++;
               $display("FAIL write: got addr=%0d data=%h cycle=%0d, required addr=%0d data=%h cycle=%0d",
                        imem_addr, imem_wdata, neg_cnt, e.addr, e.data, e.due);
            end else begin
               $display("write addr=%0d data=%h cycle=%0d", imem_addr, imem_wdata, neg_cnt);
            end
         end
      end
   end

   task automatic pulse_start(input logic with_valid, input logic [7:0] d);
      @(negedge clk);
      start    = 1'b1;
      rx_valid = with_valid;
      rx_data  = d;
      @(negedge clk);
      start    = 1'b0;
      rx_valid = 1'b0;
   endtask

   // Offers one byte and returns just after the edge that takes it. With gap
   // set, one idle cycle (optionally carrying a start pulse) precedes it.
   task automatic send_byte(input logic [7:0] b, input logic gap, input logic pulse);
      int tries = 0;
      if (gap) begin
         @(negedge clk);
         rx_valid = 1'b0;
         start    = pulse;
      end
      @(negedge clk);
      start    = 1'b0;
      rx_valid = 1'b1;
      rx_data  = b;
      while (rx_ready !== 1'b1 && tries < 50) begin
         @(negedge clk);
         tries++;
      end
      if (rx_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL byte_accept_timeout: rx_ready=%b after %0d cycles, required 1", rx_ready, tries);
      end else begin
         @(posedge clk);
      end
      #1 rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [ADDR_W-1:0] a, input logic [31:0] w, input logic legal,
                            input logic gap, input logic pulse);
      logic [31:0] wv;
      exp_t e;
      wv = w;
      for (int i = 0; i < 4; i++)
         send_byte(wv[31-8*i -: 8], gap, pulse && (i == 1));
      if (legal) begin
         e.addr = a;
         e.data = w;
         e.due  = neg_cnt + 1;
         sb.push_back(e);
      end
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (done !== 1'b1 || cpu_hold !== 1'b0 || rx_ready !== 1'b0 || error !== 1'b0) begin
         errors++;
         $display("FAIL %s_done: got done=%b cpu_hold=%b rx_ready=%b error=%b, required 1 0 0 0",
                  tag, done, cpu_hold, rx_ready, error);
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_writes_pending: got %0d missing writes, required 0", tag, sb.size());
      end
      $display("%s: done=%b cpu_hold=%b", tag, done, cpu_hold);
   endtask

   task automatic wait_error(input string tag, input logic [ADDR_W-1:0] ea);
      int n = 0;
      while (error !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (error !== 1'b1 || err_addr !== ea || cpu_hold !== 1'b1 || rx_ready !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL %s_error: got error=%b err_addr=%0d cpu_hold=%b rx_ready=%b done=%b, required 1 %0d 1 0 0",
                  tag, error, err_addr, cpu_hold, rx_ready, done, ea);
      end
      $display("%s: error=%b err_addr=%0d", tag, error, err_addr);
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if (rx_ready !== 1'b0 || imem_we !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0 ||
          error !== 1'b0 || err_addr !== '0 || imem_addr !== '0 || imem_wdata !== '0) begin
         errors++;
         $display("FAIL %s: got rdy=%b we=%b hold=%b done=%b err=%b ea=%0d ia=%0d wd=%h, required 0 0 1 0 0 0 0 0",
                  tag, rx_ready, imem_we, cpu_hold, done, error, err_addr, imem_addr, imem_wdata);
      end
      $display("%s: cpu_hold=%b rx_ready=%b", tag, cpu_hold, rx_ready);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset_state");
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("idle_after_reset");
   endtask

   task automatic test_basic_load();
      // Byte 0x00 alongside start in IDLE must not be taken as a header.
      pulse_start(1'b1, 8'h00);
      checks++;
      if (rx_ready !== 1'b1 || error !== 1'b0) begin
         errors++;
         $display("FAIL idle_start_byte: got rx_ready=%b error=%b, required 1 0", rx_ready, error);
      end
      send_byte(8'd2, 1'b0, 1'b0);
      send_word(0, 32'h20080005, 1'b1, 1'b0, 1'b0);
      send_word(1, 32'hAC080004, 1'b1, 1'b0, 1'b0);
      wait_done("basic_load");
   endtask

   task automatic test_back_to_back();
      pulse_start(1'b0, 8'h00);
      checks++;
      if (cpu_hold !== 1'b1 || done !== 1'b0 || rx_ready !== 1'b1) begin
         errors++;
         $display("FAIL restart_from_done: got cpu_hold=%b done=%b rx_ready=%b, required 1 0 1",
                  cpu_hold, done, rx_ready);
      end
      send_byte(8'd2, 1'b0, 1'b0);
      send_word(0, 32'hAC080004, 1'b1, 1'b0, 1'b0);
      send_word(1, 32'h28000001, 1'b1, 1'b0, 1'b0);
      wait_done("back_to_back");
   endtask

   task automatic test_illegal_opcode();
      pulse_start(1'b0, 8'h00);
      send_byte(8'd3, 1'b0, 1'b0);
      send_word(0, 32'h20080005, 1'b1, 1'b0, 1'b0);
      send_word(1, 32'hFC000000, 1'b0, 1'b0, 1'b0);
      wait_error("illegal_opcode", 1);
      // Bytes offered in ERR must be refused.
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'h11;
      repeat (5) @(negedge clk);
      checks++;
      if (rx_ready !== 1'b0 || error !== 1'b1) begin
         errors++;
         $display("FAIL err_holds: got rx_ready=%b error=%b, required 0 1", rx_ready, error);
      end
      rx_valid = 1'b0;
   endtask

   task automatic test_bad_header();
      logic [7:0] hdrs [2];
      hdrs[0] = 8'h00;
      hdrs[1] = 8'h41;
      for (int i = 0; i < 2; i++) begin
         pulse_start(1'b0, 8'h00);
         checks++;
         if (error !== 1'b0 || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL err_restart: got error=%b rx_ready=%b, required 0 1", error, rx_ready);
         end
         send_byte(hdrs[i], 1'b0, 1'b0);
         wait_error($sformatf("bad_header_%02h", hdrs[i]), 0);
      end
   endtask

   task automatic test_gappy_load();
      pulse_start(1'b0, 8'h00);
      send_byte(8'd2, 1'b1, 1'b0);
      send_word(0, 32'h8C010000, 1'b1, 1'b1, 1'b1);
      send_word(1, 32'h0C000010, 1'b1, 1'b1, 1'b1);
      wait_done("gappy_load");
   endtask

   task automatic test_full_depth();
      pulse_start(1'b0, 8'h00);
      send_byte(8'(DEPTH), 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++)
         send_word(ADDR_W'(i), 32'h0000_1000 + 32'(i), 1'b1, 1'b0, 1'b0);
      wait_done("full_depth");
   endtask

   task automatic test_reset_midload();
      pulse_start(1'b0, 8'h00);
      send_byte(8'd2, 1'b0, 1'b0);
      send_word(0, 32'h20080005, 1'b1, 1'b0, 1'b0);
      send_byte(8'hAC, 1'b0, 1'b0);
      send_byte(8'h08, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check_reset_outputs("reset_midload");
      repeat (4) @(negedge clk);
      pulse_start(1'b0, 8'h00);
      send_byte(8'd1, 1'b0, 1'b0);
      send_word(0, 32'h00000000, 1'b1, 1'b0, 1'b0);
      wait_done("reload_after_reset");
   endtask

   initial begin
      reset    = 1'b0;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      test_reset();
      test_basic_load();
      test_back_to_back();
      test_illegal_opcode();
      test_bad_header();
      test_gappy_load();
      test_full_depth();
      test_reset_midload();
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
